// File: rtl/bus_device_port.sv
// bus_device_port: device-side bus endpoint with TX/RX FIFOs; optional dest-ID filter under `PORT_ADDR_CHECK_EN
module bus_device_port #(
    parameter int         pckg_sz   = 16,
    parameter int         depth     = 8,
    parameter logic [7:0] id        = 8'd0,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   pndng,
    output logic [pckg_sz-1:0]     D_pop,
    input  logic                   pop,
    input  logic                   push,
    input  logic [pckg_sz-1:0]     D_push,
    input  logic                   tx_valid,
    input  logic [pckg_sz-1:0]     tx_data,
    output logic                   tx_ready,
    output logic                   rx_valid,
    output logic [pckg_sz-1:0]     rx_data,
    input  logic                   rx_ready,
    output logic [$clog2(depth):0] tx_count,
    output logic [$clog2(depth):0] rx_count,
    output logic                   rx_overflow,
    output logic                   pop_underflow,
    output logic [7:0]             misaddr_cnt
);
    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;
    localparam logic [cw-1:0] full = cw'(depth);

    logic [pckg_sz-1:0] tx_mem [depth];
    logic [pckg_sz-1:0] rx_mem [depth];
    logic [aw-1:0]      tx_wp, tx_rp, rx_wp, rx_rp;
    logic               tx_wr, tx_rd, rx_wr, rx_rd, addr_hit, rx_take;

    assign tx_ready = tx_count != full;
    assign pndng    = tx_count != '0;
    assign rx_valid = rx_count != '0;
    assign tx_wr    = tx_valid && tx_ready;
    assign tx_rd    = pop && pndng;
    assign rx_rd    = rx_valid && rx_ready;
    assign rx_take  = push && addr_hit;
    // A full RX FIFO still takes the push when the local side drains the head in the same cycle
    assign rx_wr    = rx_take && (rx_count != full || rx_ready);
    assign D_pop    = pndng ? tx_mem[tx_rp] : '0;
    assign rx_data  = rx_valid ? rx_mem[rx_rp] : '0;

`ifdef PORT_ADDR_CHECK_EN
    logic [7:0] dst;
    assign dst      = D_push[pckg_sz-1 -: 8];
    assign addr_hit = dst == id || dst == broadcast;

    // Count packets dropped by the address filter, saturating
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            misaddr_cnt <= '0;
        else if (push && !addr_hit && misaddr_cnt != 8'hFF)
            misaddr_cnt <= misaddr_cnt + 8'd1;
    end
`else
    assign addr_hit    = 1'b1;
    assign misaddr_cnt = '0;
`endif

    // FIFO storage; contents are not reset, validity comes from the counters
    always_ff @(posedge clk) begin
        if (tx_wr)
            tx_mem[tx_wp] <= tx_data;
        if (rx_wr)
            rx_mem[rx_wp] <= D_push;
    end

    // TX pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wp    <= '0;
            tx_rp    <= '0;
            tx_count <= '0;
        end else begin
            if (tx_wr)
                tx_wp <= tx_wp + aw'(1);
            if (tx_rd)
                tx_rp <= tx_rp + aw'(1);
            tx_count <= (tx_wr && !tx_rd) ? tx_count + cw'(1) :
                        (tx_rd && !tx_wr) ? tx_count - cw'(1) : tx_count;
        end
    end

    // RX pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_count <= '0;
        end else begin
            if (rx_wr)
                rx_wp <= rx_wp + aw'(1);
            if (rx_rd)
                rx_rp <= rx_rp + aw'(1);
            rx_count <= (rx_wr && !rx_rd) ? rx_count + cw'(1) :
                        (rx_rd && !rx_wr) ? rx_count - cw'(1) : rx_count;
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_overflow   <= 1'b0;
            pop_underflow <= 1'b0;
        end else begin
            if (rx_take && !rx_wr)
                rx_overflow <= 1'b1;
            if (pop && !pndng)
                pop_underflow <= 1'b1;
        end
    end
endmodule
